// File: rtl/multichannel_sample_latch.sv
// Serial-to-parallel capture into round-robin channel slots with an atomic transfer to the I2S side.
// Define SAMPLE_LATCH_OVERRUN_EN to build the per-slot written flags and the sticky overrun flag.
module multichannel_sample_latch #(
    parameter int IN_BITS   = 18,
    parameter int OUT_BITS  = 18,
    parameter int DROP_BITS = 1,
    parameter int CHANNELS  = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_data,
    input  logic                         i_bit_en,
    input  logic                         i_ad_latch,
    input  logic                         i_frame,
    input  logic                         i_i2s_latch,
    input  logic                         i_clr_overrun,
    output logic [CHANNELS*OUT_BITS-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_overrun
);

    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IN_BITS-1:0] KEEP_MASK = {IN_BITS{1'b1}} << DROP_BITS;
    localparam logic [PTR_W-1:0]   LAST_SLOT = PTR_W'(CHANNELS - 1);

    logic [IN_BITS-1:0]           shift_q, shift_d;
    logic [CHANNELS*OUT_BITS-1:0] slots_q, slots_d;
    logic [CHANNELS*OUT_BITS-1:0] data_q, data_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic                         valid_q, valid_d;
    logic [PTR_W-1:0]             cap_ptr;
    logic [IN_BITS+OUT_BITS-1:0]  aligned;
    logic [OUT_BITS-1:0]          mapped;
    int                           slot_base;

    always_comb begin
        // Appending OUT_BITS zeros and taking the top OUT_BITS covers both
        // left-justify (wider output) and LSB truncation (narrower output).
        aligned   = {shift_q & KEEP_MASK, {OUT_BITS{1'b0}}};
        mapped    = aligned[IN_BITS+OUT_BITS-1 -: OUT_BITS];
        cap_ptr   = i_frame ? '0 : ptr_q;
        slot_base = int'(cap_ptr) * OUT_BITS;

        shift_d = i_bit_en ? {shift_q[IN_BITS-2:0], i_data} : shift_q;
        slots_d = slots_q;
        ptr_d   = ptr_q;
        if (i_ad_latch) begin
            slots_d[slot_base +: OUT_BITS] = mapped;
            ptr_d = (cap_ptr == LAST_SLOT) ? '0 : cap_ptr + PTR_W'(1);
        end else if (i_frame) begin
            ptr_d = '0;
        end

        data_d  = i_i2s_latch ? slots_q : data_q;
        valid_d = i_i2s_latch;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q <= '0;
            slots_q <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            slots_q <= slots_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

`ifdef SAMPLE_LATCH_OVERRUN_EN
    logic [CHANNELS-1:0] written_q, written_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        written_d = i_i2s_latch ? '0 : written_q;
        overrun_d = i_clr_overrun ? 1'b0 : overrun_q;
        if (i_ad_latch) begin
            written_d[cap_ptr] = 1'b1;
            if (written_q[cap_ptr] && !i_i2s_latch) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            written_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            written_q <= written_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_overrun = overrun_q;
`else
    logic unused_clr_overrun;
    assign unused_clr_overrun = i_clr_overrun;
    assign o_overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_multichannel_sample_latch.sv
// Bench for multichannel_sample_latch: directed table, hand sequences and randomized
// stimulus on three differently parameterised instances sharing one input stream.
module tb_multichannel_sample_latch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, d, en, ad, fr, i2s, clr;
    logic [35:0] od0;
    logic [71:0] od1;
    logic [15:0] od2;
    logic v0, v1, v2, r0, r1, r2;

`ifdef SAMPLE_LATCH_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    multichannel_sample_latch #(.IN_BITS(18), .OUT_BITS(18), .DROP_BITS(1), .CHANNELS(2)) u0 (
        .i_clk(clk), .i_reset(rst), .i_data(d), .i_bit_en(en), .i_ad_latch(ad),
        .i_frame(fr), .i_i2s_latch(i2s), .i_clr_overrun(clr),
        .o_data(od0), .o_valid(v0), .o_overrun(r0));

    multichannel_sample_latch #(.IN_BITS(16), .OUT_BITS(24), .DROP_BITS(0), .CHANNELS(3)) u1 (
        .i_clk(clk), .i_reset(rst), .i_data(d), .i_bit_en(en), .i_ad_latch(ad),
        .i_frame(fr), .i_i2s_latch(i2s), .i_clr_overrun(clr),
        .o_data(od1), .o_valid(v1), .o_overrun(r1));

    multichannel_sample_latch #(.IN_BITS(20), .OUT_BITS(16), .DROP_BITS(1), .CHANNELS(1)) u2 (
        .i_clk(clk), .i_reset(rst), .i_data(d), .i_bit_en(en), .i_ad_latch(ad),
        .i_frame(fr), .i_i2s_latch(i2s), .i_clr_overrun(clr),
        .o_data(od2), .o_valid(v2), .o_overrun(r2));

    int IN_B   [3] = '{18, 16, 20};
    int OUT_B  [3] = '{18, 24, 16};
    int DROP_B [3] = '{1, 0, 1};
    int CH_B   [3] = '{2, 3, 1};

    // Reference model state: recent-bit window, slot words, pointer, written flags.
    longint m_sh   [3];
    longint m_slot [3][3];
    bit     m_wr   [3][3];
    int     m_ptr  [3];
    bit     m_ovr  [3];
    longint m_od   [3][3];
    bit     m_ov   [3];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic longint map_word(longint w, int ib, int ob, int db);
        longint v;
        v = w & ~((longint'(1) << db) - 1);
        if (ob >= ib) return v << (ob - ib);
        return v >> (ib - ob);
    endfunction

    task automatic model_step();
        longint w;
        int s;
        for (int m = 0; m < 3; m++) begin
            if (rst) begin
                m_sh[m] = 0; m_ptr[m] = 0; m_ovr[m] = 0; m_ov[m] = 0;
                for (int k = 0; k < 3; k++) begin
                    m_slot[m][k] = 0; m_wr[m][k] = 0; m_od[m][k] = 0;
                end
            end else begin
                w = m_sh[m];
                s = fr ? 0 : m_ptr[m];
                if (clr) m_ovr[m] = 0;
                if (i2s) for (int k = 0; k < 3; k++) m_od[m][k] = m_slot[m][k];
                m_ov[m] = i2s;
                if (ad && OVR_EN && m_wr[m][s] && !i2s) m_ovr[m] = 1;
                if (i2s) for (int k = 0; k < 3; k++) m_wr[m][k] = 0;
                if (ad) begin
                    m_slot[m][s] = map_word(w, IN_B[m], OUT_B[m], DROP_B[m]);
                    m_wr[m][s]   = 1;
                    m_ptr[m]     = (s + 1) % CH_B[m];
                end else if (fr) begin
                    m_ptr[m] = 0;
                end
                if (en) m_sh[m] = ((w << 1) | longint'(d)) & ((longint'(1) << IN_B[m]) - 1);
            end
        end
    endtask

    function automatic logic [71:0] exp_data(int m);
        logic [71:0] e;
        e = '0;
        for (int k = 0; k < CH_B[m]; k++) e |= (72'(m_od[m][k]) << (k * OUT_B[m]));
        return e;
    endfunction

    function automatic logic [71:0] act_data(int m);
        case (m)
            0:       return 72'(od0);
            1:       return od1;
            default: return 72'(od2);
        endcase
    endfunction

    task automatic check(string name, logic [71:0] act, logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic [2:0] vs, rs;
        vs = {v2, v1, v0};
        rs = {r2, r1, r0};
        for (int m = 0; m < 3; m++) begin
            check($sformatf("u%0d o_data @%0t", m, $time), act_data(m), exp_data(m));
            check($sformatf("u%0d o_valid @%0t", m, $time), 72'(vs[m]), 72'(m_ov[m]));
            check($sformatf("u%0d o_overrun @%0t", m, $time), 72'(rs[m]), 72'(m_ovr[m]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic idle();
        rst = 0; d = 0; en = 0; ad = 0; fr = 0; i2s = 0; clr = 0;
    endtask

    task automatic shift_bits(logic [19:0] val, int n);
        for (int i = n - 1; i >= 0; i--) begin
            idle();
            en = 1'b1;
            d  = val[i];
            cycle();
        end
        idle();
    endtask

    task automatic strobe(bit a, bit f, bit t, bit c, bit r);
        idle();
        ad = a; fr = f; i2s = t; clr = c; rst = r;
        cycle();
        idle();
    endtask

    typedef struct {
        logic [19:0] word;
        int          nbits;
        bit          a;
        bit          f;
        bit          t;
        logic [35:0] exp_data;
        bit          exp_valid;
    } row_t;

    row_t tbl [15];

    initial begin
        // exp_data is {ch1, ch0} of the default stereo instance after the row's strobe cycle.
        tbl[0]  = '{20'h2AAAB, 18, 1, 0, 0, 36'h0, 0};
        tbl[1]  = '{20'h15555, 18, 1, 0, 0, 36'h0, 0};
        tbl[2]  = '{20'h0, 0, 0, 0, 1, {18'h15554, 18'h2AAAA}, 1};
        tbl[3]  = '{20'h0, 0, 0, 0, 0, {18'h15554, 18'h2AAAA}, 0};
        tbl[4]  = '{20'h00100, 18, 1, 0, 0, {18'h15554, 18'h2AAAA}, 0};
        tbl[5]  = '{20'h00200, 18, 1, 0, 0, {18'h15554, 18'h2AAAA}, 0};
        tbl[6]  = '{20'h00300, 18, 1, 0, 1, {18'h00200, 18'h00100}, 1};
        tbl[7]  = '{20'h0, 0, 0, 0, 1, {18'h00200, 18'h00300}, 1};
        tbl[8]  = '{20'h0F0F0, 18, 1, 1, 0, {18'h00200, 18'h00300}, 0};
        tbl[9]  = '{20'h12345, 18, 1, 0, 0, {18'h00200, 18'h00300}, 0};
        tbl[10] = '{20'h0, 0, 0, 0, 1, {18'h12344, 18'h0F0F0}, 1};
        tbl[11] = '{20'h00001, 18, 1, 0, 0, {18'h12344, 18'h0F0F0}, 0};
        tbl[12] = '{20'h0, 0, 0, 1, 0, {18'h12344, 18'h0F0F0}, 0};
        tbl[13] = '{20'h3FFFF, 18, 1, 0, 0, {18'h12344, 18'h0F0F0}, 0};
        tbl[14] = '{20'h0, 0, 0, 0, 1, {18'h12344, 18'h3FFFE}, 1};

        idle();
        strobe(0, 0, 0, 0, 1);
        check("reset o_data", 72'(od0), 72'h0);
        check("reset o_valid", 72'(v0), 72'h0);
        check("reset o_overrun", 72'(r0), 72'h0);

        for (int r = 0; r < 15; r++) begin
            shift_bits(tbl[r].word, tbl[r].nbits);
            strobe(tbl[r].a, tbl[r].f, tbl[r].t, 0, 0);
            check($sformatf("row%0d o_data", r), 72'(od0), 72'(tbl[r].exp_data));
            check($sformatf("row%0d o_valid", r), 72'(v0), 72'(tbl[r].exp_valid));
        end

        // Width mapping: 20-in/16-out truncation, then 16-in/24-out left-justify.
        strobe(0, 0, 0, 0, 1);
        shift_bits(20'hABCDE, 20);
        strobe(1, 0, 0, 0, 0);
        strobe(0, 0, 1, 0, 0);
        check("map 20to16", 72'(od2), 72'hABCD);
        strobe(0, 0, 0, 0, 1);
        shift_bits(20'h08001, 16);
        strobe(1, 0, 0, 0, 0);
        strobe(0, 0, 1, 0, 0);
        check("map 16to24", od1, 72'h800100);

        // Overrun: three captures into two slots with no transfer between.
        strobe(0, 0, 0, 0, 1);
        shift_bits(20'h11111, 18); strobe(1, 0, 0, 0, 0);
        shift_bits(20'h22222, 18); strobe(1, 0, 0, 0, 0);
        check("overrun after 2", 72'(r0), 72'h0);
        shift_bits(20'h33333, 18); strobe(1, 0, 0, 0, 0);
        check("overrun after 3", 72'(r0), 72'(OVR_EN));
        strobe(0, 0, 0, 1, 0);
        check("overrun cleared", 72'(r0), 72'h0);
        strobe(0, 0, 1, 0, 0);
        check("overrun slot data", 72'(od0), 72'({18'h22222, 18'h33332}));

        // Reset mid-word with every strobe asserted; the partial word must be lost.
        shift_bits(20'h001FF, 9);
        strobe(1, 1, 1, 1, 1);
        check("midreset o_data", 72'(od0), 72'h0);
        check("midreset o_valid", 72'(v0), 72'h0);
        check("midreset o_overrun", 72'(r0), 72'h0);
        shift_bits(20'h00016, 5);
        strobe(1, 0, 0, 0, 0);
        strobe(0, 0, 1, 0, 0);
        check("midreset fresh", 72'(od0), 72'h16);

        for (int i = 0; i < 2000; i++) begin
            idle();
            en  = ($urandom_range(3) != 0);
            d   = 1'($urandom_range(1));
            ad  = ($urandom_range(4) == 0);
            fr  = ($urandom_range(19) == 0);
            i2s = ($urandom_range(9) == 0);
            clr = ($urandom_range(19) == 0);
            rst = ($urandom_range(199) == 0);
            cycle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
